// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W     = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned DRAIN_W   = 2;

  localparam logic [REG_W-1:0] ZERO_REG = 4'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared synchronously.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_use,
  input  logic             id_src2_use,
  input  logic             id_jr,
  input  logic [REG_W-1:0] id_jr_reg,
  input  logic             id_hlt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_we,
  input  logic             ex_mem_re,
  input  logic             ex_br_taken,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             jr_redirect,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t             state_q;
  state_t             state_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_d;
  logic               lu_c;
  logic               src_hit_c;

  // Load-use: only a load in EX is too late for forwarding; r0 never hazards.
  always_comb begin
    src_hit_c = (id_src1_use && (id_src1 == ex_dst)) ||
                (id_src2_use && (id_src2 == ex_dst)) ||
                (id_jr       && (id_jr_reg == ex_dst));
    lu_c      = ex_mem_re && ex_we && (ex_dst != ZERO_REG) && id_valid && src_hit_c;
  end

  // State and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and pipeline control; everything is quiet while in reset.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    jr_redirect  = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (ex_br_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
          end else if (lu_c) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
          end else if (id_valid && id_jr) begin
            jr_redirect  = 1'b1;
            flush_if_id  = 1'b1;
          end else if (id_valid && id_hlt) begin
            stall_pc     = 1'b1;
            flush_if_id  = 1'b1;
            state_d      = HALT_DRAIN;
            drain_d      = DRAIN_W'(DRAIN_CYC);
          end
        end
        HALT_DRAIN: begin
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
        HALTED: begin
          halted      = 1'b1;
          stall_pc    = 1'b1;
          flush_if_id = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  logic stall_inc_c;
  logic flush_inc_c;

  // Performance events count only in RUN.
  always_comb begin
    stall_inc_c = stall_pc && (state_q == RUN);
    flush_inc_c = flush_if_id && (state_q == RUN);
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (stall_inc_c),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (flush_inc_c),
    .cnt_o (flush_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/halt sequencer for the 5-stage pipeline with a 16-entry register file.
- Decides when the ID-stage JR target (resolved through the EX/MEM/WB forwarding paths) and ordinary ID operands are safe to consume.
- Inserts load-use bubbles, squashes wrong-path fetches after a JR redirect or a taken EX branch, and drains the pipe on HLT.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_W, 4, register-index width (16 registers; r0 is hardwired zero)
CNT_W, 16, width of the performance counters
DRAIN_CYC, 3, cycles from HLT leaving ID until it retires from WB

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a valid instruction
id_src1, id_src2  input  REG_W  ID source registers
id_src1_use, id_src2_use  input  1  the ID instruction reads src1/src2
id_jr  input  1  ID holds JR
id_jr_reg  input  REG_W  JR target register
id_hlt  input  1  ID holds HLT
ex_dst  input  REG_W  EX destination
ex_we  input  1  EX writes the register file
ex_mem_re  input  1  EX is a load
ex_br_taken  input  1  taken branch resolved in EX
stall_pc  output  1  hold the PC
stall_if_id  output  1  hold the IF/ID register
flush_if_id  output  1  zero IF/ID next edge
bubble_id_ex  output  1  load a NOP into ID/EX next edge
jr_redirect  output  1  PC takes the JR target this cycle
halted  output  1  the HLT has retired
stall_cnt  output  CNT_W  stall cycles since reset
flush_cnt  output  CNT_W  flush events since reset

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Next state is RUN.
  - Counters clear to 0, drain counter clears to 0.
  - While rst=1, all 1-bit outputs are 0.
- Load-use hazard, combinational:
  - lu = ex_mem_re & ex_we & (ex_dst!=0) & id_valid & ((id_src1_use & id_src1==ex_dst) | (id_src2_use & id_src2==ex_dst) | (id_jr & id_jr_reg==ex_dst)).
  - A JR whose producer is in MEM or WB, or is a non-load in EX, needs no stall; the forwarding paths cover it.
- Priority in RUN, highest first:
  1. ex_br_taken: flush_if_id=1, bubble_id_ex=1, no stall, jr_redirect=0. A JR or HLT in ID is squashed.
  2. lu: stall_pc=1, stall_if_id=1, bubble_id_ex=1. Exactly one cycle; next cycle the load is in MEM and lu clears.
  3. id_valid & id_jr: jr_redirect=1, flush_if_id=1.
  4. id_valid & id_hlt: stall_pc=1, flush_if_id=1. Next state HALT_DRAIN with drain counter = DRAIN_CYC.
- FSM states RUN, HALT_DRAIN, HALTED:
  - HALT_DRAIN:
    - stall_pc=1 and flush_if_id=1 every cycle.
    - Drain counter decrements each cycle; at 1 the next state is HALTED.
    - ex_br_taken is ignored here; only older instructions remain, and the HLT is already past ID.
  - HALTED:
    - halted=1, stall_pc=1, flush_if_id=1.
    - Remains until rst.
- Counters:
  - stall_cnt increments by 1 on each cycle with stall_pc=1 in RUN.
  - flush_cnt increments by 1 on each cycle with flush_if_id=1 in RUN.
  - Both saturate at all-ones and do not count in HALT_DRAIN/HALTED.
  - Both are registered; a value is visible the cycle after its event.
- Same-cycle ex_br_taken & lu: the branch wins and stall_cnt does not increment.
- Reset during HALT_DRAIN: returns to RUN; halted is 0 from the cycle after the reset edge.

Decomposition:
- Shared package holds:
  - state encoding (RUN=2'd0, HALT_DRAIN=2'd1, HALTED=2'd2)
  - REG_W and the constant ZERO_REG=4'd0
- One natural sub-module, sat_counter (CNT_W-bit, synchronous clear, increment enable, saturating). It is instantiated twice.
- Hazard detection and the FSM stay in the top module.

Test Plan:
- Load r5 in EX (ex_mem_re=1, ex_we=1, ex_dst=5), ID JR r5 -> one cycle with stall_pc=stall_if_id=bubble_id_ex=1 and jr_redirect=0. The next cycle, with ex_mem_re=0, gives jr_redirect=1 and flush_if_id=1. stall_cnt=1, flush_cnt=1.
- Load to r0 in EX, ID reads src1=0 -> no stall; stall_cnt stays 0.
- ex_br_taken=1 together with lu=1 and id_jr=1 -> flush_if_id=1, bubble_id_ex=1, stall_pc=0, jr_redirect=0; flush_cnt +1, stall_cnt +0.
- id_hlt=1 in RUN -> halted=0 for 4 cycles (HLT cycle plus DRAIN_CYC=3), halted=1 from the 5th cycle on; stall_pc held at 1 throughout. rst=1 then returns halted=0 and state RUN.
- stall_cnt preloaded near saturation by 65535 load-use stalls -> it holds 16'hFFFF after further stalls.
- ALU write to r7 in EX (ex_mem_re=0), ID JR r7 -> jr_redirect=1 the same cycle with no stall.
